// File: rtl/mu0_control.sv
// MU0 fetch/execute sequencer with memory-ready stalls and a halt state.
// Drives datapath enables, mux selects and memory requests from the IR opcode.
module mu0_control #(
  parameter bit USE_MEM_RDY   = 1'b1,
  parameter bit ILLEGAL_HALTS = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  F,
  input  logic        N,
  input  logic        Z,
  input  logic        mem_rdy,
  output logic        X_sel,
  output logic        Y_sel,
  output logic        Addr_sel,
  output logic [1:0]  ALU_fs,
  output logic        PC_En,
  output logic        IR_En,
  output logic        Acc_En,
  output logic        MEM_rEn,
  output logic        MEM_wEn,
  output logic        Halted,
  output logic [15:0] instr_cnt
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    EXEC  = 2'd1,
    HALT  = 2'd2
  } state_t;

  state_t state;
  logic   rdy;
  logic   mem_op;
  logic   done;
  logic   stop;

  assign rdy    = mem_rdy | ~USE_MEM_RDY;
  assign mem_op = ~F[3] & ~F[2];
  assign done   = (state == EXEC) & (rdy | ~mem_op);
  assign stop   = (F == 4'd7) | (ILLEGAL_HALTS & F[3]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= FETCH;
      instr_cnt <= 16'h0000;
    end else begin
      unique case (state)
        FETCH: if (rdy) state <= EXEC;
        EXEC: begin
          if (done) begin
            if (instr_cnt != 16'hFFFF)
              instr_cnt <= instr_cnt + 16'd1;
            state <= stop ? HALT : FETCH;
          end
        end
        HALT:    state <= HALT;
        default: state <= FETCH;
      endcase
    end
  end

  // Everything is forced low while reset is held, even though state reads FETCH.
  always_comb begin
    X_sel    = 1'b0;
    Y_sel    = 1'b0;
    Addr_sel = 1'b0;
    ALU_fs   = 2'b00;
    PC_En    = 1'b0;
    IR_En    = 1'b0;
    Acc_En   = 1'b0;
    MEM_rEn  = 1'b0;
    MEM_wEn  = 1'b0;
    Halted   = 1'b0;
    if (rst_n) begin
      unique case (state)
        FETCH: begin
          MEM_rEn = 1'b1;
          X_sel   = 1'b1;
          ALU_fs  = 2'b10;
          IR_En   = rdy;
          PC_En   = rdy;
        end
        EXEC: begin
          unique case (1'b1)
            (F == 4'd0): begin
              Addr_sel = 1'b1;
              MEM_rEn  = 1'b1;
              Acc_En   = rdy;
            end
            (F == 4'd1): begin
              Addr_sel = 1'b1;
              MEM_wEn  = 1'b1;
            end
            (F == 4'd2),
            (F == 4'd3): begin
              Addr_sel = 1'b1;
              MEM_rEn  = 1'b1;
              ALU_fs   = F[0] ? 2'b11 : 2'b01;
              Acc_En   = rdy;
            end
            (F == 4'd4): begin
              Y_sel = 1'b1;
              PC_En = 1'b1;
            end
            (F == 4'd5): begin
              Y_sel = 1'b1;
              PC_En = ~N;
            end
            (F == 4'd6): begin
              Y_sel = 1'b1;
              PC_En = ~Z;
            end
            (F == 4'd7): ;
            F[3]: ;
            default: ;
          endcase
        end
        HALT:    Halted = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mu0_control.sv
// Randomized + directed bench for mu0_control against an opcode-table model.
// Two instances run in lockstep: default parameters and ILLEGAL_HALTS=1.
module tb_mu0_control;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] F = 4'd0;
  logic       N = 1'b0;
  logic       Z = 1'b0;
  logic       mem_rdy = 1'b0;

  logic        x_sel[2], y_sel[2], addr_sel[2];
  logic [1:0]  alu_fs[2];
  logic        pc_en[2], ir_en[2], acc_en[2];
  logic        mem_ren[2], mem_wen[2], halted[2];
  logic [15:0] cnt[2];
  logic [10:0] obs[2];

  always #5 clk = ~clk;

  mu0_control #(.USE_MEM_RDY(1'b1), .ILLEGAL_HALTS(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .F(F), .N(N), .Z(Z), .mem_rdy(mem_rdy),
    .X_sel(x_sel[0]), .Y_sel(y_sel[0]), .Addr_sel(addr_sel[0]),
    .ALU_fs(alu_fs[0]), .PC_En(pc_en[0]), .IR_En(ir_en[0]),
    .Acc_En(acc_en[0]), .MEM_rEn(mem_ren[0]), .MEM_wEn(mem_wen[0]),
    .Halted(halted[0]), .instr_cnt(cnt[0])
  );

  mu0_control #(.USE_MEM_RDY(1'b1), .ILLEGAL_HALTS(1'b1)) dut_ih (
    .clk(clk), .rst_n(rst_n), .F(F), .N(N), .Z(Z), .mem_rdy(mem_rdy),
    .X_sel(x_sel[1]), .Y_sel(y_sel[1]), .Addr_sel(addr_sel[1]),
    .ALU_fs(alu_fs[1]), .PC_En(pc_en[1]), .IR_En(ir_en[1]),
    .Acc_En(acc_en[1]), .MEM_rEn(mem_ren[1]), .MEM_wEn(mem_wen[1]),
    .Halted(halted[1]), .instr_cnt(cnt[1])
  );

  assign obs[0] = {x_sel[0], y_sel[0], addr_sel[0], alu_fs[0], pc_en[0],
                   ir_en[0], acc_en[0], mem_ren[0], mem_wen[0], halted[0]};
  assign obs[1] = {x_sel[1], y_sel[1], addr_sel[1], alu_fs[1], pc_en[1],
                   ir_en[1], acc_en[1], mem_ren[1], mem_wen[1], halted[1]};

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Model phase: 0 = fetching, 1 = executing, 2 = halted
  int          mph[2];
  int unsigned mcnt[2];

  function automatic logic [10:0] model_out(int ph, logic [3:0] f,
                                            logic n, logic z,
                                            logic r, logic rn);
    logic xs, ys, as, pc, ir, acc, re, we, h;
    logic [1:0] fs;
    {xs, ys, as, fs, pc, ir, acc, re, we, h} = '0;
    if (rn) begin
      if (ph == 0) begin
        re = 1; xs = 1; fs = 2'b10; ir = r; pc = r;
      end else if (ph == 2) begin
        h = 1;
      end else if (f <= 4'd3) begin
        as  = 1;
        re  = (f != 4'd1);
        we  = (f == 4'd1);
        acc = (f != 4'd1) && r;
        fs  = (f == 4'd2) ? 2'b01 : (f == 4'd3) ? 2'b11 : 2'b00;
      end else if (f <= 4'd6) begin
        ys = 1;
        pc = (f == 4'd4) ? 1'b1 : (f == 4'd5) ? ~n : ~z;
      end
    end
    return {xs, ys, as, fs, pc, ir, acc, re, we, h};
  endfunction

  task automatic cyc(logic [3:0] f, logic n, logic z, logic r,
                     logic rn, string tag);
    @(negedge clk);
    F = f; N = n; Z = z; mem_rdy = r; rst_n = rn;
    if (!rn) begin
      for (int i = 0; i < 2; i++) begin
        mph[i] = 0;
        mcnt[i] = 0;
      end
    end
    #1;
    for (int i = 0; i < 2; i++) begin
      check($sformatf("%s/out%0d", tag, i), 32'(obs[i]),
            32'(model_out(mph[i], f, n, z, r, rn)));
      check($sformatf("%s/cnt%0d", tag, i), 32'(cnt[i]), mcnt[i]);
    end
    @(posedge clk);
    if (rn) begin
      for (int i = 0; i < 2; i++) begin
        if (mph[i] == 0) begin
          if (r) mph[i] = 1;
        end else if (mph[i] == 1 && (r || f >= 4'd4)) begin
          if (mcnt[i] < 32'hFFFF) mcnt[i]++;
          mph[i] = (f == 4'd7 || (i == 1 && f >= 4'd8)) ? 2 : 0;
        end
      end
    end
  endtask

  task automatic instr(logic [3:0] f, logic n, logic z, string tag);
    cyc(f, n, z, 1'b1, 1'b1, {tag, "_f"});
    cyc(f, n, z, 1'b1, 1'b1, {tag, "_e"});
  endtask

  initial begin
    mph[0] = 0; mph[1] = 0; mcnt[0] = 0; mcnt[1] = 0;

    cyc(4'd0, 0, 0, 1, 0, "rst");
    cyc(4'd0, 0, 0, 1, 0, "rst2");

    instr(4'd0, 0, 0, "lda");
    #1 check("lda_cnt", 32'(cnt[0]), 32'd1);

    instr(4'd5, 1, 0, "jge_n1");
    instr(4'd5, 0, 0, "jge_n0");
    instr(4'd6, 0, 1, "jne_z1");
    instr(4'd6, 0, 0, "jne_z0");
    instr(4'd1, 0, 0, "sta");
    instr(4'd4, 1, 1, "jmp");

    cyc(4'd2, 0, 0, 1, 1, "add_f");
    for (int k = 0; k < 3; k++) cyc(4'd2, 0, 0, 0, 1, "add_stall");
    cyc(4'd2, 0, 0, 1, 1, "add_done");
    #1 check("add_cnt", 32'(cnt[0]), 32'd8);

    instr(4'd7, 0, 0, "stp");
    for (int k = 0; k < 10; k++)
      cyc(4'($urandom), 1'($urandom), 1'($urandom), 1'(k), 1, "halt_hold");
    cyc(4'd0, 0, 0, 1, 0, "halt_rst");
    cyc(4'd0, 0, 0, 1, 1, "post_rst");
    #1 check("post_rst_halt", 32'(halted[0]), 32'd0);

    instr(4'd9, 0, 0, "ill");
    #1 check("ill_halt_ih", 32'(halted[1]), 32'd1);
    cyc(4'd9, 0, 0, 1, 1, "ill_next");
    cyc(4'd0, 0, 0, 1, 0, "ill_rst");

    cyc(4'd0, 0, 0, 0, 1, "sat_stall");
    @(negedge clk);
    force dut.instr_cnt = 16'hFFFE;
    force dut_ih.instr_cnt = 16'hFFFE;
    #1;
    release dut.instr_cnt;
    release dut_ih.instr_cnt;
    mcnt[0] = 32'hFFFE;
    mcnt[1] = 32'hFFFE;
    instr(4'd0, 0, 0, "sat1");
    instr(4'd2, 0, 0, "sat2");
    instr(4'd3, 0, 0, "sat3");
    #1 check("sat_cnt", 32'(cnt[0]), 32'hFFFF);

    cyc(4'd0, 0, 0, 0, 1, "mid_f");
    cyc(4'd0, 0, 0, 0, 0, "mid_rst");
    #1 check("mid_ren", 32'(mem_ren[0]), 32'd0);

    for (int k = 0; k < 3000; k++) begin
      logic [3:0] f;
      logic rn;
      f = ($urandom_range(0, 15) == 0) ? 4'd7 : 4'($urandom);
      rn = !(((mph[0] == 2) || (mph[1] == 2)) && $urandom_range(0, 3) == 0)
           && ($urandom_range(0, 63) != 0);
      cyc(f, 1'($urandom), 1'($urandom), 1'($urandom_range(0, 2) != 0),
          rn, "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
